// File: rtl/vx_dot8_arbiter_pkg.sv
// Shared types and sizing helpers for the DOT8 arbiter and its ID FIFO.
package vx_dot8_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Requester-select width; at least one bit so NUM_REQS=1 still has a legal index.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_dot8_arbiter_if.sv
// Issue, unit and response handshakes between requesters, arbiter and DOT8 unit.
interface vx_dot8_arbiter_if #(
    parameter int NUM_REQS  = 4,
    parameter int REQ_WIDTH = 256,
    parameter int RSP_WIDTH = 128
);
    logic [NUM_REQS-1:0]                req_valid;
    logic [NUM_REQS-1:0][REQ_WIDTH-1:0] req_data;
    logic [NUM_REQS-1:0]                req_sop;
    logic [NUM_REQS-1:0]                req_eop;
    logic [NUM_REQS-1:0]                req_ready;

    logic                 unit_valid;
    logic [REQ_WIDTH-1:0] unit_data;
    logic                 unit_sop;
    logic                 unit_eop;
    logic                 unit_ready;

    logic                 rsp_in_valid;
    logic [RSP_WIDTH-1:0] rsp_in_data;
    logic                 rsp_in_eop;
    logic                 rsp_in_ready;

    logic [NUM_REQS-1:0]  rsp_valid;
    logic [RSP_WIDTH-1:0] rsp_data;
    logic                 rsp_eop;
    logic [NUM_REQS-1:0]  rsp_ready;

    modport slave (
        input  req_valid, req_data, req_sop, req_eop, unit_ready,
               rsp_in_valid, rsp_in_data, rsp_in_eop, rsp_ready,
        output req_ready, unit_valid, unit_data, unit_sop, unit_eop,
               rsp_in_ready, rsp_valid, rsp_data, rsp_eop
    );

    modport master (
        output req_valid, req_data, req_sop, req_eop, unit_ready,
               rsp_in_valid, rsp_in_data, rsp_in_eop, rsp_ready,
        input  req_ready, unit_valid, unit_data, unit_sop, unit_eop,
               rsp_in_ready, rsp_valid, rsp_data, rsp_eop
    );

endinterface

// File: rtl/vx_dot8_arbiter_id_fifo.sv
// In-order FIFO of granted requester indices; depth may be any value >= 1.
module vx_dot8_arbiter_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            // Push and pop together leave the occupancy unchanged.
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vx_dot8_arbiter.sv
// Packet-locked round-robin arbiter sharing one DOT8 unit, with in-order response routing.
module vx_dot8_arbiter
    import vx_dot8_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int REQ_WIDTH   = 256,
    parameter int RSP_WIDTH   = 128,
    parameter int MAX_PENDING = 4,
    parameter bit ASSERT_EN   = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    vx_dot8_arbiter_if.slave bus
);
    localparam int SEL_BITS = sel_bits(NUM_REQS);
    localparam int CNT_BITS = cnt_bits(MAX_PENDING);
    localparam logic [CNT_BITS-1:0] MAX_CNT  = CNT_BITS'(MAX_PENDING);
    localparam logic [SEL_BITS-1:0] LAST_REQ = SEL_BITS'(NUM_REQS - 1);

    arb_state_e          state;
    logic                active;
    logic [SEL_BITS-1:0] rr_ptr, lock_idx, pick, idx, win, head;
    logic [CNT_BITS-1:0] count;
    logic [NUM_REQS-1:0] ready_vec, rsp_vec;
    logic                lock, credit, nonempty, any_valid, go;
    logic                win_sop, win_eop, unit_valid, fire, push, pop, rsp_in_ready;

    assign lock     = (state == ARB_LOCKED);
    assign credit   = (count < MAX_CNT);
    assign nonempty = (count != '0);

    // Scan downward so the requester nearest to rr_ptr+1 is the last to be written.
    always_comb begin
        pick      = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQS; i >= 1; i--) begin
            idx = SEL_BITS'((int'(rr_ptr) + i) % NUM_REQS);
            if (bus.req_valid[idx]) begin
                pick      = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Outputs stay quiet until the first clock after reset release.
    assign win     = lock ? lock_idx : pick;
    assign go      = active & (lock | (any_valid & credit));
    assign win_sop = bus.req_sop[win];
    assign win_eop = bus.req_eop[win];

    assign unit_valid = go & bus.req_valid[win];
    assign fire       = unit_valid & bus.unit_ready;
    assign push       = fire & win_sop;

    always_comb begin
        ready_vec      = '0;
        ready_vec[win] = go & bus.unit_ready;
    end

    assign bus.req_ready  = ready_vec;
    assign bus.unit_valid = unit_valid;
    assign bus.unit_data  = bus.req_data[win];
    assign bus.unit_sop   = win_sop;
    assign bus.unit_eop   = win_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            state    <= ARB_IDLE;
            lock_idx <= '0;
            rr_ptr   <= LAST_REQ;
        end else begin
            active <= 1'b1;
            if (fire) begin
                if (win_sop && !win_eop) begin
                    state    <= ARB_LOCKED;
                    lock_idx <= win;
                end else if (win_eop) begin
                    state  <= ARB_IDLE;
                    rr_ptr <= win;
                end
            end
        end
    end

    vx_dot8_arbiter_id_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (SEL_BITS),
        .CNT_W (CNT_BITS)
    ) id_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (win),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign rsp_in_ready = nonempty & bus.rsp_ready[head];
    assign pop          = bus.rsp_in_valid & rsp_in_ready & bus.rsp_in_eop;

    always_comb begin
        rsp_vec       = '0;
        rsp_vec[head] = nonempty & bus.rsp_in_valid;
    end

    assign bus.rsp_valid    = rsp_vec;
    assign bus.rsp_in_ready = rsp_in_ready;
    assign bus.rsp_data     = bus.rsp_in_data;
    assign bus.rsp_eop      = bus.rsp_in_eop;

    always_ff @(posedge clk) begin
        if (ASSERT_EN && active) begin
            assert (!(bus.rsp_in_valid && !nonempty));
            assert (!(fire && !win_sop && !lock));
        end
    end

endmodule

// File: tb/tb_vx_dot8_arbiter.sv
// Directed and random checks of the DOT8 arbiter against a queue-based reference model.
module tb_vx_dot8_arbiter;
    localparam int N  = 4;
    localparam int RW = 32;
    localparam int SW = 16;
    localparam int MP = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    vx_dot8_arbiter_if #(.NUM_REQS(N), .REQ_WIDTH(RW), .RSP_WIDTH(SW)) bus ();

    vx_dot8_arbiter #(
        .NUM_REQS(N), .REQ_WIDTH(RW), .RSP_WIDTH(SW), .MAX_PENDING(MP), .ASSERT_EN(1'b0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total;
    int bad;

    // Reference model: last packet winner, lock owner and the queue of pending packet owners.
    int m_rr;
    int m_lock;
    int m_lidx;
    int m_q[$];

    logic [N-1:0]  e_rready;
    logic [N-1:0]  o_rready;
    logic [N-1:0]  o_rv;
    logic          o_uv;
    logic          o_rir;
    logic [SW-1:0] o_rdata;
    int            o_grant;
    int            grants[N];
    int            left[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr   = N - 1;
        m_lock = 0;
        m_lidx = 0;
        m_q.delete();
    endtask

    task automatic clr_reqs();
        bus.req_valid = '0;
        bus.req_sop   = '0;
        bus.req_eop   = '0;
    endtask

    task automatic put(input int i, input bit s, input bit e);
        bus.req_valid[i] = 1'b1;
        bus.req_sop[i]   = s;
        bus.req_eop[i]   = e;
        bus.req_data[i]  = $urandom;
    endtask

    task automatic rsp_auto();
        bus.rsp_in_valid = (m_q.size() != 0);
        bus.rsp_in_eop   = 1'b1;
        bus.rsp_in_data  = SW'($urandom);
        bus.rsp_ready    = '1;
    endtask

    // Called just after a negedge with inputs set; checks, advances the model, waits one cycle.
    task automatic step(input string tag);
        int w;
        int h;
        bit credit;
        bit go;
        bit e_uv;
        bit ne;
        logic [N-1:0] e_rv;
        #1;
        credit = (m_q.size() < MP);
        w = -1;
        if (m_lock != 0) w = m_lidx;
        else for (int k = 1; k <= N; k++)
            if (w < 0 && bus.req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        go   = (w >= 0) && ((m_lock != 0) || credit);
        e_uv = go && bus.req_valid[w];
        e_rready = '0;
        if (go && bus.unit_ready) e_rready[w] = 1'b1;
        ne = (m_q.size() != 0);
        h  = ne ? m_q[0] : 0;
        e_rv = '0;
        if (ne && bus.rsp_in_valid) e_rv[h] = 1'b1;

        o_rready = bus.req_ready;
        o_uv     = bus.unit_valid;
        o_rv     = bus.rsp_valid;
        o_rir    = bus.rsp_in_ready;
        o_rdata  = bus.rsp_data;
        o_grant  = -1;
        if (o_uv && bus.unit_ready)
            for (int k = 0; k < N; k++) if (o_rready[k]) o_grant = k;

        chk({tag, ".unit_valid"}, 64'(o_uv), 64'(e_uv));
        chk({tag, ".req_ready"}, 64'(o_rready), 64'(e_rready));
        if (e_uv) begin
            chk({tag, ".unit_data"}, 64'(bus.unit_data), 64'(bus.req_data[w]));
            chk({tag, ".unit_sop"}, 64'(bus.unit_sop), 64'(bus.req_sop[w]));
            chk({tag, ".unit_eop"}, 64'(bus.unit_eop), 64'(bus.req_eop[w]));
        end
        chk({tag, ".rsp_valid"}, 64'(o_rv), 64'(e_rv));
        chk({tag, ".rsp_in_ready"}, 64'(o_rir), 64'(ne && bus.rsp_ready[h]));
        chk({tag, ".rsp_data"}, 64'(o_rdata), 64'(bus.rsp_in_data));
        chk({tag, ".rsp_eop"}, 64'(bus.rsp_eop), 64'(bus.rsp_in_eop));

        if (e_uv && bus.unit_ready) begin
            if (bus.req_sop[w]) m_q.push_back(w);
            if (bus.req_sop[w] && !bus.req_eop[w]) begin
                m_lock = 1;
                m_lidx = w;
            end else if (bus.req_eop[w]) begin
                m_lock = 0;
                m_rr   = w;
            end
        end
        if (bus.rsp_in_valid && ne && bus.rsp_ready[h] && bus.rsp_in_eop) void'(m_q.pop_front());
        @(negedge clk);
    endtask

    task automatic drain();
        clr_reqs();
        for (int k = 0; k < 8 && m_q.size() != 0; k++) begin
            rsp_auto();
            step("drain");
        end
        bus.rsp_in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        model_reset();
        bus.req_valid = '1;
        bus.req_sop   = '1;
        bus.req_eop   = '1;
        for (int i = 0; i < N; i++) bus.req_data[i] = $urandom;
        bus.unit_ready   = 1'b1;
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_eop   = 1'b1;
        bus.rsp_in_data  = '0;
        bus.rsp_ready    = '1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst.unit_valid", 64'(bus.unit_valid), 64'(0));
        chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst.rsp_in_ready", 64'(bus.rsp_in_ready), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        bus.rsp_in_valid = 1'b0;
        @(negedge clk);

        // Fairness: every requester always has a single-beat packet ready.
        for (int i = 0; i < N; i++) grants[i] = 0;
        for (int c = 0; c < 100; c++) begin
            rsp_auto();
            step("fair");
            chk("fair.order", 64'(o_grant), 64'(c % N));
            if (o_grant >= 0 && o_grant < N) begin
                grants[o_grant]++;
                bus.req_data[o_grant] = $urandom;
            end
        end
        for (int i = 0; i < N; i++) chk("fair.count", 64'(grants[i]), 64'(25));

        // Packet lock: requester 0 waits for all three beats of requester 2.
        clr_reqs();
        put(2, 1'b1, 1'b0);
        rsp_auto();
        step("lock");
        chk("lock.beat0", 64'(o_grant), 64'(2));
        put(2, 1'b0, 1'b0);
        put(0, 1'b1, 1'b1);
        rsp_auto();
        step("lock");
        chk("lock.beat1", 64'(o_grant), 64'(2));
        put(2, 1'b0, 1'b1);
        rsp_auto();
        step("lock");
        chk("lock.beat2", 64'(o_grant), 64'(2));
        bus.req_valid[2] = 1'b0;
        rsp_auto();
        step("lock");
        chk("lock.after", 64'(o_grant), 64'(0));

        // Credit stall: four packets fill the ID FIFO, the fifth waits for a pop.
        drain();
        put(1, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step("credit");
            chk("credit.accept", 64'(o_rready), (c < 4) ? 64'h2 : 64'h0);
            if (c < 4) bus.req_data[1] = $urandom;
        end
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_eop   = 1'b1;
        bus.rsp_ready    = '1;
        step("credit");
        chk("credit.pop_cycle", 64'(o_rready), 64'h0);
        chk("credit.pop_ready", 64'(o_rir), 64'h1);
        bus.rsp_in_valid = 1'b0;
        step("credit");
        chk("credit.resume", 64'(o_rready), 64'h2);

        // Response routing for packets from requesters 1, 3, 1.
        drain();
        put(1, 1'b1, 1'b1);
        step("route");
        chk("route.issue0", 64'(o_grant), 64'(1));
        clr_reqs();
        put(3, 1'b1, 1'b1);
        step("route");
        chk("route.issue1", 64'(o_grant), 64'(3));
        clr_reqs();
        put(1, 1'b1, 1'b1);
        step("route");
        chk("route.issue2", 64'(o_grant), 64'(1));
        clr_reqs();
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_eop   = 1'b1;
        bus.rsp_in_data  = 16'hAAAA;
        bus.rsp_ready    = '1;
        step("route");
        chk("route.rsp0", 64'(o_rv), 64'h2);
        chk("route.data0", 64'(o_rdata), 64'hAAAA);
        bus.rsp_in_data = 16'hBBBB;
        bus.rsp_ready   = 4'b0111;
        step("route");
        chk("route.rsp1", 64'(o_rv), 64'h8);
        chk("route.stall", 64'(o_rir), 64'h0);
        step("route");
        chk("route.hold", 64'(o_rv), 64'h8);
        chk("route.hold_data", 64'(o_rdata), 64'hBBBB);
        bus.rsp_ready = '1;
        step("route");
        chk("route.release", 64'(o_rir), 64'h1);
        bus.rsp_in_data = 16'hCCCC;
        step("route");
        chk("route.rsp2", 64'(o_rv), 64'h2);
        step("route");
        chk("route.empty_ready", 64'(o_rir), 64'h0);
        chk("route.empty_valid", 64'(o_rv), 64'h0);
        bus.rsp_in_valid = 1'b0;

        // Push and pop in the same cycle at MAX_PENDING-1 keeps the occupancy.
        put(0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("pushpop");
            bus.req_data[0] = $urandom;
        end
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_eop   = 1'b1;
        bus.rsp_ready    = '1;
        step("pushpop");
        chk("pushpop.push", 64'(o_rready), 64'h1);
        chk("pushpop.pop", 64'(o_rir), 64'h1);
        bus.rsp_in_valid = 1'b0;
        bus.req_data[0]  = $urandom;
        step("pushpop");
        chk("pushpop.last_credit", 64'(o_rready), 64'h1);
        step("pushpop");
        chk("pushpop.full", 64'(o_rready), 64'h0);
        drain();

        // Random traffic: variable-length packets, random backpressure and responses.
        for (int i = 0; i < N; i++) left[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    bit s;
                    s = 1'b0;
                    if (left[i] == 0) begin
                        left[i] = $urandom_range(1, 3);
                        s = 1'b1;
                    end
                    put(i, s, left[i] == 1);
                end
            end
            bus.unit_ready   = ($urandom_range(0, 3) != 0);
            bus.rsp_in_valid = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
            bus.rsp_in_eop   = ($urandom_range(0, 1) == 1);
            bus.rsp_in_data  = SW'($urandom);
            bus.rsp_ready    = N'($urandom) | N'($urandom);
            step("rand");
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && e_rready[i]) begin
                    bus.req_valid[i] = 1'b0;
                    left[i]--;
                end
            end
        end

        // Reset mid-packet must drop the lock.
        clr_reqs();
        bus.rsp_in_valid = 1'b0;
        bus.unit_ready   = 1'b1;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        put(2, 1'b1, 1'b0);
        step("midrst");
        chk("midrst.lock", 64'(o_grant), 64'(2));
        put(2, 1'b0, 1'b0);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        put(2, 1'b1, 1'b1);
        put(0, 1'b1, 1'b1);
        step("midrst");
        chk("midrst.unlocked", 64'(o_grant), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
